// File: rtl/ddr_burst_reader.sv
// ddr_burst_reader
//
// Command-driven DDR read engine. One fetch command (byte base address +
// 64-bit word count) is split into bursts of at most MAX_BURST words. Each
// burst is requested on the burst_read_* handshake only when the output FIFO
// has room for every beat of it. Returned beats are buffered in a
// first-word-fall-through FIFO and presented as a valid/ready stream.
//
// Ports
//   user_clk, user_rst     clock, asynchronous active-high reset
//   cmd_valid/cmd_ready    fetch command handshake (ready only in IDLE)
//   cmd_addr, cmd_words    byte base address (low 3 bits ignored), word count
//   burst_read_req         one-cycle burst request pulse
//   burst_read_addr/len    burst byte address / length in words, held until finish
//   burst_read_data/valid  returned word and its strobe
//   burst_read_finish      end-of-burst pulse
//   m_data/m_valid/m_ready output stream (FIFO head)
//   busy                   engine not idle
//   done                   one-cycle pulse when all beats of a command arrived
//   err                    sticky protocol error, cleared only by reset
module ddr_burst_reader #(
   parameter int DATA_WIDTH = 64,
   parameter int ADDR_SIZE  = 32,
   parameter int LEN_WIDTH  = 16,
   parameter int CNT_WIDTH  = 20,
   parameter int MAX_BURST  = 16,
   parameter int FIFO_DEPTH = 64
) (
   input  logic                  user_clk,
   input  logic                  user_rst,
   input  logic                  cmd_valid,
   output logic                  cmd_ready,
   input  logic [ADDR_SIZE-1:0]  cmd_addr,
   input  logic [CNT_WIDTH-1:0]  cmd_words,
   output logic                  burst_read_req,
   output logic [ADDR_SIZE-1:0]  burst_read_addr,
   output logic [LEN_WIDTH-1:0]  burst_read_len,
   input  logic [DATA_WIDTH-1:0] burst_read_data,
   input  logic                  burst_read_valid,
   input  logic                  burst_read_finish,
   output logic [DATA_WIDTH-1:0] m_data,
   output logic                  m_valid,
   input  logic                  m_ready,
   output logic                  busy,
   output logic                  done,
   output logic                  err
);

   localparam int AW  = $clog2(FIFO_DEPTH);
   localparam int CW  = AW + 1;
   localparam int LW1 = LEN_WIDTH + 1;

   typedef enum logic [2:0] {
      S_IDLE,
      S_CHECK,
      S_REQ,
      S_DATA,
      S_DONE
   } state_t;

   state_t                 state_q;
   logic [ADDR_SIZE-1:0]   addr_q;
   logic [CNT_WIDTH-1:0]   remaining_q;
   logic [LW1-1:0]         beat_cnt_q;
   logic                   cmd_ready_q;
   logic                   burst_read_req_q;
   logic [ADDR_SIZE-1:0]   burst_read_addr_q;
   logic [LEN_WIDTH-1:0]   burst_read_len_q;
   logic                   busy_q;
   logic                   done_q;
   logic                   err_q;

   // FIFO storage and bookkeeping
   logic [DATA_WIDTH-1:0]  fifo_mem [FIFO_DEPTH];
   logic [AW-1:0]          wr_ptr_q;
   logic [AW-1:0]          rd_ptr_q;
   logic [CW-1:0]          count_q;

   logic [CNT_WIDTH-1:0]   chunk_w;
   logic [LEN_WIDTH-1:0]   cur_len_w;
   logic [CW-1:0]          space_w;
   logic                   space_ok_w;
   logic                   fifo_full_w;
   logic                   in_data_w;
   logic                   beat_room_w;
   logic                   push_w;
   logic                   pop_w;
   logic                   beat_err_w;
   logic [LW1-1:0]         beats_total_w;
   logic                   burst_last_w;

   // Next burst length: whatever is left, capped at MAX_BURST.
   assign chunk_w   = (remaining_q > CNT_WIDTH'(MAX_BURST)) ? CNT_WIDTH'(MAX_BURST) : remaining_q;
   assign cur_len_w = LEN_WIDTH'(chunk_w);

   // Space is judged on the count seen in CHECK; pops in flight only add room.
   assign space_w     = CW'(FIFO_DEPTH) - count_q;
   assign space_ok_w  = 32'(space_w) >= 32'(cur_len_w);
   assign fifo_full_w = (count_q == CW'(FIFO_DEPTH));

   assign in_data_w   = (state_q == S_DATA);
   assign beat_room_w = (beat_cnt_q < {1'b0, burst_read_len_q});
   assign push_w      = burst_read_valid && in_data_w && beat_room_w && !fifo_full_w;
   assign pop_w       = m_valid && m_ready;

   // Any beat that is not accepted is an error, except in IDLE where stale
   // traffic from before a reset may still be draining out of the memory.
   assign beat_err_w  = burst_read_valid && (state_q != S_IDLE) && !push_w;

   // Beats of this burst including one arriving together with finish.
   assign beats_total_w = beat_cnt_q + LW1'(burst_read_valid);
   assign burst_last_w  = (remaining_q == CNT_WIDTH'(burst_read_len_q));

   always_ff @(posedge user_clk or posedge user_rst) begin
      if (user_rst) begin
         state_q           <= S_IDLE;
         addr_q            <= '0;
         remaining_q       <= '0;
         beat_cnt_q        <= '0;
         cmd_ready_q       <= 1'b1;
         burst_read_req_q  <= 1'b0;
         burst_read_addr_q <= '0;
         burst_read_len_q  <= '0;
         busy_q            <= 1'b0;
         done_q            <= 1'b0;
         err_q             <= 1'b0;
      end else begin
         burst_read_req_q <= 1'b0;
         done_q           <= 1'b0;
         if (beat_err_w) begin
            err_q <= 1'b1;
         end
         case (state_q)
            S_IDLE: begin
               if (cmd_valid) begin
                  addr_q      <= cmd_addr & ~ADDR_SIZE'(7);
                  remaining_q <= cmd_words;
                  cmd_ready_q <= 1'b0;
                  busy_q      <= 1'b1;
                  if (cmd_words == '0) begin
                     state_q <= S_DONE;
                     done_q  <= 1'b1;
                  end else begin
                     state_q <= S_CHECK;
                  end
               end
            end
            S_CHECK: begin
               if (space_ok_w) begin
                  burst_read_addr_q <= addr_q;
                  burst_read_len_q  <= cur_len_w;
                  burst_read_req_q  <= 1'b1;
                  state_q           <= S_REQ;
               end
            end
            S_REQ: begin
               beat_cnt_q <= '0;
               state_q    <= S_DATA;
            end
            S_DATA: begin
               if (push_w) begin
                  beat_cnt_q <= beat_cnt_q + LW1'(1);
               end
               if (burst_read_finish) begin
                  if (beats_total_w != {1'b0, burst_read_len_q}) begin
                     err_q <= 1'b1;
                  end
                  // Address wraps modulo 2^ADDR_SIZE.
                  addr_q      <= addr_q + ADDR_SIZE'({burst_read_len_q, 3'b000});
                  remaining_q <= remaining_q - CNT_WIDTH'(burst_read_len_q);
                  if (burst_last_w) begin
                     state_q <= S_DONE;
                     done_q  <= 1'b1;
                  end else begin
                     state_q <= S_CHECK;
                  end
               end
            end
            S_DONE: begin
               state_q     <= S_IDLE;
               cmd_ready_q <= 1'b1;
               busy_q      <= 1'b0;
            end
            default: begin
               state_q <= S_IDLE;
            end
         endcase
      end
   end

   // FIFO pointers and occupancy.
   always_ff @(posedge user_clk or posedge user_rst) begin
      if (user_rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (push_w) begin
            wr_ptr_q <= wr_ptr_q + AW'(1);
         end
         if (pop_w) begin
            rd_ptr_q <= rd_ptr_q + AW'(1);
         end
         case ({push_w, pop_w})
            2'b10:   count_q <= count_q + CW'(1);
            2'b01:   count_q <= count_q - CW'(1);
            default: count_q <= count_q;
         endcase
      end
   end

   // Storage has no reset; the head is masked to zero while empty so the
   // stream output is defined straight out of reset.
   always_ff @(posedge user_clk) begin
      if (push_w) begin
         fifo_mem[wr_ptr_q] <= burst_read_data;
      end
   end

   assign m_valid = (count_q != '0);
   assign m_data  = m_valid ? fifo_mem[rd_ptr_q] : '0;

   assign cmd_ready       = cmd_ready_q;
   assign burst_read_req  = burst_read_req_q;
   assign burst_read_addr = burst_read_addr_q;
   assign burst_read_len  = burst_read_len_q;
   assign busy            = busy_q;
   assign done            = done_q;
   assign err             = err_q;

endmodule

// File: tb/tb_ddr_burst_reader.sv
module tb_ddr_burst_reader;

   logic        user_clk = 1'b0;
   logic        user_rst = 1'b1;
   logic        cmd_valid;
   logic        cmd_ready;
   logic [31:0] cmd_addr;
   logic [19:0] cmd_words;
   logic        burst_read_req;
   logic [31:0] burst_read_addr;
   logic [15:0] burst_read_len;
   logic [63:0] burst_read_data;
   logic        burst_read_valid;
   logic        burst_read_finish;
   logic [63:0] m_data;
   logic        m_valid;
   logic        m_ready;
   logic        busy;
   logic        done;
   logic        err;

   ddr_burst_reader dut (
      .user_clk          (user_clk),
      .user_rst          (user_rst),
      .cmd_valid         (cmd_valid),
      .cmd_ready         (cmd_ready),
      .cmd_addr          (cmd_addr),
      .cmd_words         (cmd_words),
      .burst_read_req    (burst_read_req),
      .burst_read_addr   (burst_read_addr),
      .burst_read_len    (burst_read_len),
      .burst_read_data   (burst_read_data),
      .burst_read_valid  (burst_read_valid),
      .burst_read_finish (burst_read_finish),
      .m_data            (m_data),
      .m_valid           (m_valid),
      .m_ready           (m_ready),
      .busy              (busy),
      .done              (done),
      .err               (err)
   );

   always #5 user_clk = ~user_clk;

   // Reference model state: expected stream words and expected bursts.
   logic [63:0] exp_data[$];
   logic [31:0] exp_baddr[$];
   logic [15:0] exp_blen[$];
   logic [31:0] log_addr[$];
   logic [15:0] log_len[$];

   int checks = 0;
   int errors = 0;
   int done_count = 0;
   bit err_allowed = 1'b0;
   bit short_mode = 1'b0;
   int ready_mode = 1;    // 0 stall, 1 always ready, 2 random
   logic done_prev = 1'b0;

   // Contents of the simulated DDR: every word encodes its own address.
   function automatic logic [63:0] mem_word(input logic [31:0] a);
      return {a, a ^ 32'hA5A5_5A5A};
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Command split rule: min(remaining,16) words per burst, address += len*8.
   task automatic build_model(input logic [31:0] addr, input int words, input bit short_bursts);
      logic [31:0] a;
      int rem;
      int l;
      a = addr & 32'hFFFF_FFF8;
      rem = words;
      while (rem > 0) begin
         l = (rem > 16) ? 16 : rem;
         exp_baddr.push_back(a);
         exp_blen.push_back(16'(l));
         for (int i = 0; i < (short_bursts ? l - 1 : l); i++) begin
            exp_data.push_back(mem_word(a + 32'(i) * 32'd8));
         end
         a = a + 32'(l) * 32'd8;
         rem = rem - l;
      end
   endtask

   task automatic clear_model();
      exp_data.delete();
      exp_baddr.delete();
      exp_blen.delete();
   endtask

   // Single compare process: requests, stream words, err, done shape.
   always @(negedge user_clk) begin
      if (!user_rst) begin
         if (burst_read_req) begin
            log_addr.push_back(burst_read_addr);
            log_len.push_back(burst_read_len);
            $display("req  addr=%h len=%0d", burst_read_addr, burst_read_len);
            if (exp_baddr.size() == 0) begin
               chk("unexpected_req", {32'd0, burst_read_addr}, 64'hFFFF_FFFF_FFFF_FFFF);
            end else begin
               chk("req_addr", {32'd0, burst_read_addr}, {32'd0, exp_baddr.pop_front()});
               chk("req_len", {48'd0, burst_read_len}, {48'd0, exp_blen.pop_front()});
            end
         end
         if (m_valid && m_ready) begin
            $display("pop  data=%h", m_data);
            if (exp_data.size() == 0) begin
               chk("unexpected_pop", m_data, ~m_data);
            end else begin
               chk("m_data", m_data, exp_data.pop_front());
            end
         end
         if (!err_allowed) begin
            chk("err_clean", {63'd0, err}, 64'd0);
         end
         if (done) begin
            done_count++;
            $display("done");
            chk("done_one_cycle", {63'd0, done_prev}, 64'd0);
         end
         done_prev = done;
      end else begin
         done_prev = 1'b0;
      end
   end

   // Consumer.
   initial begin
      m_ready = 1'b0;
      forever begin
         @(negedge user_clk);
         if (ready_mode == 2) m_ready = 1'($urandom_range(0, 1));
         else m_ready = (ready_mode == 1);
      end
   end

   // Simulated DDR responder.
   task automatic serve(input logic [31:0] a, input logic [15:0] l);
      int n;
      int i;
      bit fin_with_last;
      n = short_mode ? int'(l) - 1 : int'(l);
      i = 0;
      fin_with_last = 1'($urandom_range(0, 1));
      while (i < n) begin
         @(negedge user_clk);
         if (user_rst) begin
            burst_read_valid = 1'b0;
            burst_read_finish = 1'b0;
            return;
         end
         if ($urandom_range(0, 3) != 0) begin
            burst_read_valid = 1'b1;
            burst_read_data = mem_word(a + 32'(i) * 32'd8);
            i++;
            burst_read_finish = (i == n) && fin_with_last;
         end else begin
            burst_read_valid = 1'b0;
         end
      end
      @(negedge user_clk);
      burst_read_valid = 1'b0;
      if (burst_read_finish) begin
         burst_read_finish = 1'b0;
      end else if (!user_rst) begin
         burst_read_finish = 1'b1;
         @(negedge user_clk);
         burst_read_finish = 1'b0;
      end
   endtask

   initial begin
      burst_read_valid = 1'b0;
      burst_read_finish = 1'b0;
      burst_read_data = '0;
      forever begin
         @(negedge user_clk);
         if (!user_rst && burst_read_req) serve(burst_read_addr, burst_read_len);
      end
   end

   task automatic issue(input logic [31:0] addr, input int words);
      @(negedge user_clk);
      chk("cmd_ready_idle", {63'd0, cmd_ready}, 64'd1);
      cmd_addr = addr;
      cmd_words = 20'(words);
      cmd_valid = 1'b1;
      @(negedge user_clk);
      cmd_valid = 1'b0;
   endtask

   task automatic wait_done(input int target, input int limit);
      int k;
      k = 0;
      while (done_count < target && k < limit) begin
         @(negedge user_clk);
         k++;
      end
      @(negedge user_clk);
      chk("done_count", 64'(done_count), 64'(target));
   endtask

   task automatic wait_drain(input int limit);
      int k;
      k = 0;
      while (exp_data.size() != 0 && k < limit) begin
         @(negedge user_clk);
         k++;
      end
      chk("drained", 64'(exp_data.size()), 64'd0);
      chk("bursts_issued", 64'(exp_baddr.size()), 64'd0);
   endtask

   task automatic run_cmd(input logic [31:0] addr, input int words);
      int base;
      $display("cmd  addr=%h words=%0d", addr, words);
      build_model(addr, words, short_mode);
      base = done_count;
      issue(addr, words);
      wait_done(base + 1, 3000);
      wait_drain(3000);
   endtask

   task automatic do_reset();
      @(negedge user_clk);
      #2 user_rst = 1'b1;
      clear_model();
      repeat (3) @(negedge user_clk);
      #2 user_rst = 1'b0;
   endtask

   task automatic chk_reset_values(input string tag);
      chk({tag, "_cmd_ready"}, {63'd0, cmd_ready}, 64'd1);
      chk({tag, "_req"}, {63'd0, burst_read_req}, 64'd0);
      chk({tag, "_baddr"}, {32'd0, burst_read_addr}, 64'd0);
      chk({tag, "_blen"}, {48'd0, burst_read_len}, 64'd0);
      chk({tag, "_m_valid"}, {63'd0, m_valid}, 64'd0);
      chk({tag, "_m_data"}, m_data, 64'd0);
      chk({tag, "_busy"}, {63'd0, busy}, 64'd0);
      chk({tag, "_done"}, {63'd0, done}, 64'd0);
      chk({tag, "_err"}, {63'd0, err}, 64'd0);
   endtask

   initial begin
      int base;
      int k;
      cmd_valid = 1'b0;
      cmd_addr = '0;
      cmd_words = '0;
      repeat (3) @(negedge user_clk);
      chk_reset_values("rst");
      #2 user_rst = 1'b0;

      // Single short command.
      ready_mode = 1;
      log_addr.delete(); log_len.delete();
      run_cmd(32'h0000_1000, 5);
      chk("t1_nreq", 64'(log_addr.size()), 64'd1);
      chk("t1_addr", {32'd0, log_addr[0]}, 64'h1000);
      chk("t1_len", {48'd0, log_len[0]}, 64'd5);

      // Split command.
      log_addr.delete(); log_len.delete();
      run_cmd(32'h0000_2000, 40);
      chk("t2_nreq", 64'(log_addr.size()), 64'd3);
      chk("t2_addr0", {32'd0, log_addr[0]}, 64'h2000);
      chk("t2_addr1", {32'd0, log_addr[1]}, 64'h2080);
      chk("t2_addr2", {32'd0, log_addr[2]}, 64'h2100);
      chk("t2_len0", {48'd0, log_len[0]}, 64'd16);
      chk("t2_len2", {48'd0, log_len[2]}, 64'd8);

      // Back-pressure: FIFO fills with exactly four bursts.
      ready_mode = 0;
      log_addr.delete(); log_len.delete();
      build_model(32'h0000_3000, 100, 1'b0);
      base = done_count;
      issue(32'h0000_3000, 100);
      repeat (400) @(negedge user_clk);
      chk("bp_nreq_stalled", 64'(log_addr.size()), 64'd4);
      chk("bp_m_valid", {63'd0, m_valid}, 64'd1);
      chk("bp_busy", {63'd0, busy}, 64'd1);
      chk("bp_no_done", 64'(done_count), 64'(base));
      ready_mode = 2;
      wait_done(base + 1, 3000);
      wait_drain(3000);
      chk("bp_nreq_total", 64'(log_addr.size()), 64'd7);

      // Zero-length command.
      ready_mode = 1;
      log_addr.delete(); log_len.delete();
      base = done_count;
      issue(32'h0000_4000, 0);
      repeat (4) @(negedge user_clk);
      chk("zero_done", 64'(done_count), 64'(base + 1));
      chk("zero_nreq", 64'(log_addr.size()), 64'd0);
      chk("zero_cmd_ready", {63'd0, cmd_ready}, 64'd1);

      // Random commands, including an address that wraps.
      ready_mode = 2;
      for (int n = 0; n < 5; n++) begin
         run_cmd($urandom, $urandom_range(1, 70));
      end
      run_cmd(32'hFFFF_FFE3, 9);

      // Short burst: 3 beats for len 4.
      err_allowed = 1'b1;
      short_mode = 1'b1;
      ready_mode = 1;
      run_cmd(32'h0000_5000, 4);
      chk("short_err", {63'd0, err}, 64'd1);
      repeat (10) @(negedge user_clk);
      chk("short_err_sticky", {63'd0, err}, 64'd1);
      short_mode = 1'b0;
      do_reset();
      err_allowed = 1'b0;
      @(negedge user_clk);
      chk("err_cleared", {63'd0, err}, 64'd0);

      // Stray beat while waiting in CHECK for FIFO space.
      ready_mode = 0;
      log_addr.delete(); log_len.delete();
      build_model(32'h0000_8000, 100, 1'b0);
      issue(32'h0000_8000, 100);
      repeat (400) @(negedge user_clk);
      chk("stray_nreq", 64'(log_addr.size()), 64'd4);
      chk("stray_err_before", {63'd0, err}, 64'd0);
      err_allowed = 1'b1;
      burst_read_valid = 1'b1;
      burst_read_data = 64'hDEAD_BEEF_0000_0001;
      @(negedge user_clk);
      burst_read_valid = 1'b0;
      @(negedge user_clk);
      chk("stray_err", {63'd0, err}, 64'd1);
      do_reset();
      err_allowed = 1'b0;

      // Reset in the middle of the second burst.
      ready_mode = 1;
      log_addr.delete(); log_len.delete();
      build_model(32'h0000_6000, 40, 1'b0);
      issue(32'h0000_6000, 40);
      k = 0;
      while (log_addr.size() < 2 && k < 300) begin
         @(negedge user_clk);
         k++;
      end
      chk("mid_second_req", 64'(log_addr.size()), 64'd2);
      repeat (2) @(negedge user_clk);
      #2 user_rst = 1'b1;
      #1;
      chk_reset_values("midrst");
      clear_model();
      repeat (3) @(negedge user_clk);
      #2 user_rst = 1'b0;
      ready_mode = 2;
      run_cmd(32'h0000_7008, 7);

      chk("final_err", {63'd0, err}, 64'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #500000;
      errors++;
      $display("FAIL watchdog: got timeout expected completion");
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
